keypad_entry_buffer: RTL and testbench

- Sits directly downstream of the keypad scanner (column shift register, row debouncers, row scanner).
- Qualifies each raw key code with a press/release state machine: one action per physical press, hold is ignored.
- Assembles up to 4 digits into a BCD entry register, and supports backspace, clear and enter.
- Its BCD outputs feed the 7-segment display control.

---
 rtl/keypad_entry_buffer.sv | 198 +++++++++++++++++++
 tb/tb_keypad_entry_buffer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_buffer.sv
// Keypad entry buffer: qualifies scanner key codes (one action per press)
// and assembles a 4-digit BCD entry with backspace, clear and enter.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   scan_tick     : one-clk strobe per full column scan
//   key_valid     : key down in the current scan
//   key_code[3:0] : scanner key code
//   entry_bcd     : digits being typed, [3:0] is the most recent
//   digit_count   : digits held in entry_bcd (0..4)
//   entry_full    : digit_count == 4
//   value_bcd     : last committed entry
//   value_valid   : one-clk pulse when value_bcd updates
//   key_strobe    : one-clk pulse per accepted press
//   key_last      : code of the last accepted press
module keypad_entry_buffer #(
  parameter int unsigned CONFIRM_TICKS = 3,
  parameter int unsigned RELEASE_TICKS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_tick,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [15:0] entry_bcd,
  output logic [2:0]  digit_count,
  output logic        entry_full,
  output logic [15:0] value_bcd,
  output logic        value_valid,
  output logic        key_strobe,
  output logic [3:0]  key_last
);

  localparam logic [3:0] CT = 4'(CONFIRM_TICKS);
  localparam logic [3:0] RT = 4'(RELEASE_TICKS);

  localparam logic [3:0] K_BKSP  = 4'hA;
  localparam logic [3:0] K_CLEAR = 4'hB;
  localparam logic [3:0] K_ENTER = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONFIRM,
    S_ACT,
    S_HELD
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cand_q, cand_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  rel_q, rel_d;

  logic [15:0] entry_q, entry_d;
  logic [2:0]  count_q, count_d;
  logic [15:0] value_q, value_d;
  logic        vvalid_q, vvalid_d;
  logic        strobe_q, strobe_d;
  logic [3:0]  last_q, last_d;

  // The action registers load on the same edge the FSM enters ACT, so
  // the results are visible during the single ACT cycle.
  logic        do_act;
  logic [3:0]  act_code;
  logic        is_digit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cand_q   <= '0;
      cnt_q    <= '0;
      rel_q    <= '0;
      entry_q  <= '0;
      count_q  <= '0;
      value_q  <= '0;
      vvalid_q <= 1'b0;
      strobe_q <= 1'b0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      rel_q    <= rel_d;
      entry_q  <= entry_d;
      count_q  <= count_d;
      value_q  <= value_d;
      vvalid_q <= vvalid_d;
      strobe_q <= strobe_d;
      last_q   <= last_d;
    end
  end

  // Press/release qualification
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    rel_d    = rel_q;
    do_act   = 1'b0;
    act_code = cand_q;
    unique case (state_q)
      S_IDLE: begin
        if (scan_tick && key_valid) begin
          cand_d   = key_code;
          cnt_d    = 4'd1;
          act_code = key_code;
          if (CT == 4'd1) begin
            state_d = S_ACT;
            do_act  = 1'b1;
          end else begin
            state_d = S_CONFIRM;
          end
        end
      end
      S_CONFIRM: begin
        if (scan_tick) begin
          if (key_valid && key_code == cand_q) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_d == CT) begin
              state_d = S_ACT;
              do_act  = 1'b1;
            end
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
      end
      S_ACT: begin
        state_d = S_HELD;
        cnt_d   = '0;
        rel_d   = '0;
      end
      S_HELD: begin
        if (scan_tick) begin
          if (key_valid) begin
            rel_d = '0;
          end else begin
            rel_d = rel_q + 4'd1;
            if (rel_d == RT) begin
              state_d = S_IDLE;
              rel_d   = '0;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign is_digit = (act_code <= 4'd9);

  // Entry editing actions
  always_comb begin
    entry_d  = entry_q;
    count_d  = count_q;
    value_d  = value_q;
    vvalid_d = 1'b0;
    strobe_d = 1'b0;
    last_d   = last_q;
    if (do_act) begin
      strobe_d = 1'b1;
      last_d   = act_code;
      unique case (1'b1)
        is_digit: begin
          if (count_q < 3'd4) begin
            entry_d = {entry_q[11:0], act_code};
            count_d = count_q + 3'd1;
          end
        end
        (act_code == K_BKSP): begin
          if (count_q != 3'd0) begin
            entry_d = {4'h0, entry_q[15:4]};
            count_d = count_q - 3'd1;
          end
        end
        (act_code == K_CLEAR): begin
          entry_d = '0;
          count_d = '0;
        end
        (act_code == K_ENTER): begin
          value_d  = entry_q;
          vvalid_d = 1'b1;
          entry_d  = '0;
          count_d  = '0;
        end
        default: ;
      endcase
    end
  end

  assign entry_bcd   = entry_q;
  assign digit_count = count_q;
  assign entry_full  = (count_q == 3'd4);
  assign value_bcd   = value_q;
  assign value_valid = vvalid_q;
  assign key_strobe  = strobe_q;
  assign key_last    = last_q;

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Directed testbench for keypad_entry_buffer.
// Drives scan ticks on negedges and checks registered outputs.
module tb_keypad_entry_buffer;

  logic        clk;
  logic        rst;
  logic        scan_tick;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] entry_bcd;
  logic [2:0]  digit_count;
  logic        entry_full;
  logic [15:0] value_bcd;
  logic        value_valid;
  logic        key_strobe;
  logic [3:0]  key_last;

  int checks;
  int failures;
  int strobe_cnt;
  int vv_cnt;
  int base_s;
  int base_v;

  keypad_entry_buffer #(
    .CONFIRM_TICKS(3),
    .RELEASE_TICKS(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .scan_tick(scan_tick),
    .key_valid(key_valid),
    .key_code(key_code),
    .entry_bcd(entry_bcd),
    .digit_count(digit_count),
    .entry_full(entry_full),
    .value_bcd(value_bcd),
    .value_valid(value_valid),
    .key_strobe(key_strobe),
    .key_last(key_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    strobe_cnt = 0;
    vv_cnt = 0;
  end

  // Count cycles that each pulse is high
  always @(posedge clk) begin
    if (key_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
    if (value_valid === 1'b1) vv_cnt <= vv_cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic v, input logic [3:0] c);
    @(negedge clk);
    scan_tick = 1'b1;
    key_valid = v;
    key_code  = c;
    @(negedge clk);
    scan_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic ticks(input int n, input logic v, input logic [3:0] c);
    for (int i = 0; i < n; i++) tick(v, c);
  endtask

  task automatic press(input logic [3:0] c);
    ticks(3, 1'b1, c);
    ticks(3, 1'b0, 4'h0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    scan_tick = 1'b1;
    key_valid = 1'b1;
    key_code  = 4'h5;

    // Reset with key activity present
    @(negedge clk);
    @(negedge clk);
    chk("rst_entry", 32'(entry_bcd), 32'h0);
    chk("rst_count", 32'(digit_count), 32'h0);
    chk("rst_full", 32'(entry_full), 32'h0);
    chk("rst_value", 32'(value_bcd), 32'h0);
    chk("rst_vvalid", 32'(value_valid), 32'h0);
    chk("rst_strobe", 32'(key_strobe), 32'h0);
    chk("rst_last", 32'(key_last), 32'h0);
    rst       = 1'b0;
    scan_tick = 1'b0;
    key_valid = 1'b0;
    @(negedge clk);
    chk("rst_nostrobe", 32'(strobe_cnt), 32'd0);

    press(4'h5);
    chk("first_entry", 32'(entry_bcd), 32'h0005);
    chk("first_count", 32'(digit_count), 32'd1);

    // Two ticks is not enough to qualify
    base_s = strobe_cnt;
    ticks(2, 1'b1, 4'h7);
    ticks(3, 1'b0, 4'h0);
    chk("short_nostrobe", 32'(strobe_cnt - base_s), 32'd0);
    chk("short_entry", 32'(entry_bcd), 32'h0005);

    // Three ticks qualifies; long hold gives one action
    base_s = strobe_cnt;
    ticks(3, 1'b1, 4'h7);
    chk("q_strobe", 32'(strobe_cnt - base_s), 32'd1);
    chk("q_last", 32'(key_last), 32'h7);
    ticks(50, 1'b1, 4'h7);
    chk("hold_strobe", 32'(strobe_cnt - base_s), 32'd1);
    chk("hold_entry", 32'(entry_bcd), 32'h0057);
    ticks(3, 1'b0, 4'h0);

    // Clear then 1..5
    press(4'hB);
    chk("clr0_entry", 32'(entry_bcd), 32'h0);
    base_s = strobe_cnt;
    press(4'h1);
    press(4'h2);
    press(4'h3);
    press(4'h4);
    chk("four_entry", 32'(entry_bcd), 32'h1234);
    chk("four_full", 32'(entry_full), 32'h1);
    press(4'h5);
    chk("five_entry", 32'(entry_bcd), 32'h1234);
    chk("five_count", 32'(digit_count), 32'd4);
    chk("five_strobes", 32'(strobe_cnt - base_s), 32'd5);
    chk("five_last", 32'(key_last), 32'h5);

    // Backspace / clear / backspace at empty
    press(4'hA);
    chk("bksp_entry", 32'(entry_bcd), 32'h0123);
    chk("bksp_count", 32'(digit_count), 32'd3);
    chk("bksp_full", 32'(entry_full), 32'h0);
    press(4'hB);
    chk("clr_entry", 32'(entry_bcd), 32'h0);
    chk("clr_count", 32'(digit_count), 32'd0);
    base_s = strobe_cnt;
    press(4'hA);
    chk("bksp0_entry", 32'(entry_bcd), 32'h0);
    chk("bksp0_count", 32'(digit_count), 32'd0);
    chk("bksp0_strobe", 32'(strobe_cnt - base_s), 32'd1);

    // Enter
    press(4'h9);
    press(4'h8);
    base_v = vv_cnt;
    press(4'hF);
    chk("ent_value", 32'(value_bcd), 32'h0098);
    chk("ent_pulse", 32'(vv_cnt - base_v), 32'd1);
    chk("ent_entry", 32'(entry_bcd), 32'h0);
    chk("ent_count", 32'(digit_count), 32'd0);
    press(4'hF);
    chk("ent0_value", 32'(value_bcd), 32'h0);
    chk("ent0_pulse", 32'(vv_cnt - base_v), 32'd2);

    // Non-editing keys
    press(4'hD);
    chk("d_last", 32'(key_last), 32'hD);
    chk("d_entry", 32'(entry_bcd), 32'h0);

    // Code change during confirm
    base_s = strobe_cnt;
    tick(1'b1, 4'h3);
    tick(1'b1, 4'h3);
    tick(1'b1, 4'h6);
    ticks(3, 1'b0, 4'h0);
    chk("bounce_strobe", 32'(strobe_cnt - base_s), 32'd0);
    chk("bounce_entry", 32'(entry_bcd), 32'h0);

    // Short drop during hold does not re-arm
    ticks(3, 1'b1, 4'h4);
    ticks(2, 1'b0, 4'h0);
    ticks(3, 1'b1, 4'h4);
    ticks(3, 1'b0, 4'h0);
    chk("drop_strobe", 32'(strobe_cnt - base_s), 32'd1);
    chk("drop_entry", 32'(entry_bcd), 32'h0004);

    // Reset while held
    press(4'hF);
    chk("pre_value", 32'(value_bcd), 32'h0004);
    press(4'h1);
    ticks(3, 1'b1, 4'h2);
    chk("pre_entry", 32'(entry_bcd), 32'h0012);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_entry", 32'(entry_bcd), 32'h0);
    chk("mrst_count", 32'(digit_count), 32'd0);
    chk("mrst_value", 32'(value_bcd), 32'h0);
    chk("mrst_last", 32'(key_last), 32'h0);
    base_s = strobe_cnt;
    ticks(3, 1'b0, 4'h0);
    press(4'h6);
    chk("post_entry", 32'(entry_bcd), 32'h0006);
    chk("post_strobe", 32'(strobe_cnt - base_s), 32'd1);
    chk("post_last", 32'(key_last), 32'h6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
